rv32_alu: RTL and testbench
===========================

Name: rv32_alu

Overview:
RV32I integer ALU for the single-cycle core's execute stage. It computes the result and the V/C/Z/N flags combinationally from two 32-bit operands and a 4-bit operation code. A small clocked flag register holds the last committed flags for downstream use, such as branch and debug logic. Result and live flags have zero latency and do not depend on the clock.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported and required.

Ports:
- clk  in  1  core clock; used only by the flag register.
- rst  in  1  reset; asynchronous, active-high.
- rs1  in  32  operand A.
- rs2  in  32  operand B; bits [4:0] give the shift amount.
- ALUControl  in  4  operation select.
- flags_we  in  1  capture live flags into flags_q at the rising clk edge.
- rd  out  32  result; combinational.
- flags  out  4  live flags, combinational: [0] V range overflow, [1] C carry/borrow, [2] Z zero, [3] N sign.
- flags_q  out  4  registered copy of flags.

Behaviour:
- Opcodes:
  - 0000 ADD: rd = rs1+rs2 mod 2^32.
  - 1000 SUB: rd = rs1-rs2 mod 2^32.
  - 0001 SLL: rd = rs1 << rs2[4:0].
  - 0010 SLT: rd = {31'b0, signed(rs1) < signed(rs2)}.
  - 0011 SLTU: rd = {31'b0, unsigned compare}.
  - 0100 XOR, 0110 OR, 0111 AND: bitwise.
  - 0101 SRL: logical shift right by rs2[4:0].
  - 1101 SRA: arithmetic shift right by rs2[4:0], sign-filled.
  - All other codes: rd = 0.
- Shifts: only rs2[4:0] is used; rs2[31:5] is ignored. A shift amount of 0 passes rs1 through.
- Adder: one shared 33-bit adder computes {0,rs1} + {0,rs2}, or {0,rs1} - {0,rs2} for SUB.
- C (ADD/SUB only): bit 32 of the 33-bit adder result, i.e. carry-out for ADD, borrow for SUB. C is 0 for all other ops.
- V (ADD/SUB only): 1 if the result wrapped either unsigned or signed. For ADD: carry-out, or both operands the same sign and result sign differs. For SUB: borrow, or operand signs differ and result sign differs from rs1. V is 0 for all other ops.
- Z = (rd == 0) for every opcode, including SLT/SLTU and undefined codes.
- N = rd[31] for every opcode.
- rd and flags settle within the same delta/evaluation after any input change; no clock is involved.
- flags_q:
  - Reset to 4'b0000 asynchronously while rst=1.
  - On a rising clk edge with rst=0 and flags_we=1, flags_q <= flags.
  - Otherwise flags_q holds.
  - rst asserted mid-cycle clears flags_q immediately; combinational outputs are unaffected by rst.
- No X propagation from undefined opcodes: all outputs are fully defined.

Optional Feature:
- Macro ALU_STICKY_OVF_EN.
- When defined:
  - Adds input sticky_clr (1) and output sticky_ovf (1).
  - sticky_ovf resets to 0 asynchronously on rst.
  - On a clk edge: if sticky_clr=1, sticky_ovf is cleared (clear wins over set).
  - Else if flags_we=1 and V=1, sticky_ovf is set to 1.
  - Otherwise sticky_ovf holds.
- When undefined: neither port exists and no extra flops are generated.

Test Plan:
- ADD 20+30 -> rd=50, flags=4'b0000. SUB 8-3 -> rd=5, V=0, C=0, Z=0, N=0.
- SLL 27<<4 -> rd=432. SRL 8>>3 -> 1. SRA 8>>>3 -> 1. SRA 0x80000000>>>4 -> 0xF8000000.
- SLT 8,3 -> rd=0. SLT 0xFFFFFFFF,1 -> 1. SLTU 0xFFFFFFFF,1 -> 0. XOR 10^5 -> 15. OR 20|30 -> 30. AND 20&30 -> 20.
- ADD 0xFFFFFFFF+1 -> rd=0, V=1, C=1, Z=1, N=0. SUB 1-0xFFFFFFFF -> rd=2, V=1, C=1.
- SUB 20-20 -> Z=1. SUB 20-30 -> Z=0, N=1, C=1. SUB -2-30 -> rd=0xFFFFFFE0, N=1. ADD -20+30 -> rd=10, N=0.
- Register path: rst=1 -> flags_q=0. With flags_we=1, one clk after ADD 0xFFFFFFFF+1 -> flags_q=4'b0111. With flags_we=0, flags_q holds. Asserting rst mid-cycle -> flags_q=0 immediately. With ALU_STICKY_OVF_EN, sticky_ovf=1 after that edge, and sticky_clr=1 with V=1 on the same edge -> 0.

Source files
------------

// File: rtl/rv32_alu.sv
// RV32I execute-stage ALU: combinational result and V/C/Z/N flags plus a clocked flag register.
// Optional sticky overflow bit (sticky_clr / sticky_ovf) is built when ALU_STICKY_OVF_EN is defined.
module rv32_alu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [3:0]      ALUControl,
  input  logic            flags_we,
`ifdef ALU_STICKY_OVF_EN
  input  logic            sticky_clr,
  output logic            sticky_ovf,
`endif
  output logic [XLEN-1:0] rd,
  output logic [3:0]      flags,
  output logic [3:0]      flags_q
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1101;

  logic            is_sub_s;
  logic            is_arith_s;
  logic [XLEN:0]   b_ext_s;
  logic [XLEN:0]   sum_s;
  logic [4:0]      shamt_s;
  logic [XLEN-1:0] rd_s;
  logic            v_s;
  logic            c_s;
  logic            sgn_ovf_s;
  logic [3:0]      flags_d;

  assign is_sub_s   = (ALUControl == OP_SUB);
  assign is_arith_s = (ALUControl == OP_ADD) || is_sub_s;
  assign shamt_s    = rs2[4:0];

  // Subtraction reuses the adder as rs1 + ~rs2 + 1; bit XLEN is then the borrow.
  assign b_ext_s = is_sub_s ? ~{1'b0, rs2} : {1'b0, rs2};
  assign sum_s   = {1'b0, rs1} + b_ext_s + {{XLEN{1'b0}}, is_sub_s};

  always_comb begin
    rd_s = {XLEN{1'b0}};
    case (ALUControl)
      OP_ADD, OP_SUB: rd_s = sum_s[XLEN-1:0];
      OP_SLL:         rd_s = rs1 << shamt_s;
      OP_SLT:         rd_s = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
      OP_SLTU:        rd_s = {{(XLEN-1){1'b0}}, (rs1 < rs2)};
      OP_XOR:         rd_s = rs1 ^ rs2;
      OP_SRL:         rd_s = rs1 >> shamt_s;
      OP_OR:          rd_s = rs1 | rs2;
      OP_AND:         rd_s = rs1 & rs2;
      OP_SRA:         rd_s = $unsigned($signed(rs1) >>> shamt_s);
      default:        rd_s = {XLEN{1'b0}};
    endcase
  end

  // V flags any wrap: unsigned carry/borrow or signed range overflow.
  always_comb begin
    sgn_ovf_s = 1'b0;
    if (is_sub_s) begin
      sgn_ovf_s = (rs1[XLEN-1] != rs2[XLEN-1]) && (sum_s[XLEN-1] != rs1[XLEN-1]);
    end else begin
      sgn_ovf_s = (rs1[XLEN-1] == rs2[XLEN-1]) && (sum_s[XLEN-1] != rs1[XLEN-1]);
    end
  end

  assign c_s   = is_arith_s & sum_s[XLEN];
  assign v_s   = is_arith_s & (sum_s[XLEN] | sgn_ovf_s);
  assign rd    = rd_s;
  assign flags = {rd_s[XLEN-1], (rd_s == {XLEN{1'b0}}), c_s, v_s};

  assign flags_d = flags_we ? flags : flags_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= 4'b0000;
    end else begin
      flags_q <= flags_d;
    end
  end

`ifdef ALU_STICKY_OVF_EN
  logic sticky_ovf_d;
  logic sticky_ovf_q;

  // Clear has priority so software can acknowledge even while overflow persists.
  always_comb begin
    sticky_ovf_d = sticky_ovf_q;
    if (sticky_clr) begin
      sticky_ovf_d = 1'b0;
    end else if (flags_we && v_s) begin
      sticky_ovf_d = 1'b1;
    end else begin
      sticky_ovf_d = sticky_ovf_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_ovf_q <= 1'b0;
    end else begin
      sticky_ovf_q <= sticky_ovf_d;
    end
  end

  assign sticky_ovf = sticky_ovf_q;
`endif

endmodule

// File: tb/tb_rv32_alu.sv
// Scoreboard bench for rv32_alu: stimulus pushes reference results, a negedge monitor pops and compares.
module tb_rv32_alu;

  logic        clk;
  logic        rst;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [3:0]  ALUControl;
  logic        flags_we;
  logic [31:0] rd;
  logic [3:0]  flags;
  logic [3:0]  flags_q;
`ifdef ALU_STICKY_OVF_EN
  logic        sticky_clr;
  logic        sticky_ovf;
`endif

  rv32_alu #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .rs1        (rs1),
    .rs2        (rs2),
    .ALUControl (ALUControl),
    .flags_we   (flags_we),
`ifdef ALU_STICKY_OVF_EN
    .sticky_clr (sticky_clr),
    .sticky_ovf (sticky_ovf),
`endif
    .rd         (rd),
    .flags      (flags),
    .flags_q    (flags_q)
  );

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic [3:0]  fl;
    logic [3:0]  fq;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [3:0]  fq_model;
  logic        last_we;
  logic [3:0]  last_flags;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model straight from the opcode definitions, using wide integer arithmetic.
  function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [3:0] f);
    longint unsigned u;
    longint          s;
    logic            c;
    logic            v;
    int              sh;
    c  = 1'b0;
    v  = 1'b0;
    sh = int'(b % 32);
    case (op)
      4'b0000: begin
        u = longint'({32'h0, a}) + longint'({32'h0, b});
        s = longint'($signed(a)) + longint'($signed(b));
        r = u[31:0];
        c = (u > 64'h0000_0000_FFFF_FFFF);
        v = c || (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b1000: begin
        s = longint'($signed(a)) - longint'($signed(b));
        r = a - b;
        c = (a < b);
        v = c || (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0001: r = a << sh;
      4'b0010: r = (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
      4'b0011: r = (longint'({32'h0, a}) < longint'({32'h0, b})) ? 32'd1 : 32'd0;
      4'b0100: r = a ^ b;
      4'b0101: r = a >> sh;
      4'b0110: r = a | b;
      4'b0111: r = a & b;
      4'b1101: r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      default: r = 32'h0;
    endcase
    f = {r[31], (r == 32'h0), c, v};
  endfunction

  task automatic step(input string name, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic we);
    exp_t        e;
    logic [31:0] r;
    logic [3:0]  f;
    @(posedge clk);
    if (last_we) fq_model = last_flags;
    #1;
    ALUControl = op;
    rs1        = a;
    rs2        = b;
    flags_we   = we;
    ref_alu(op, a, b, r, f);
    e.name = name;
    e.rd   = r;
    e.fl   = f;
    e.fq   = fq_model;
    sb_q.push_back(e);
    last_we    = we;
    last_flags = f;
  endtask

  // Monitor: the ALU output is valid every cycle; compare whatever the stimulus has queued.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk({e.name, ".rd"}, rd, e.rd);
      chk({e.name, ".flags"}, {28'h0, flags}, {28'h0, e.fl});
      chk({e.name, ".flags_q"}, {28'h0, flags_q}, {28'h0, e.fq});
    end
  end

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'(($urandom_range(0, 3)));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst        = 1'b1;
    rs1        = 32'h0;
    rs2        = 32'h0;
    ALUControl = 4'b0000;
    flags_we   = 1'b0;
    fq_model   = 4'b0000;
    last_we    = 1'b0;
    last_flags = 4'b0000;
`ifdef ALU_STICKY_OVF_EN
    sticky_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset_flags_q", {28'h0, flags_q}, 32'h0);
    rst = 1'b0;

    step("add_20_30",   4'b0000, 32'd20, 32'd30, 1'b0);
    step("sub_8_3",     4'b1000, 32'd8, 32'd3, 1'b0);
    step("sll_27_4",    4'b0001, 32'd27, 32'd4, 1'b0);
    step("srl_8_3",     4'b0101, 32'd8, 32'd3, 1'b0);
    step("sra_8_3",     4'b1101, 32'd8, 32'd3, 1'b0);
    step("sra_neg_4",   4'b1101, 32'h8000_0000, 32'd4, 1'b0);
    step("sra_hi_bits", 4'b1101, 32'h8000_0000, 32'hFFFF_FFE4, 1'b0);
    step("shift_zero",  4'b0001, 32'h1234_5678, 32'h0000_0020, 1'b0);
    step("slt_8_3",     4'b0010, 32'd8, 32'd3, 1'b0);
    step("slt_m1_1",    4'b0010, 32'hFFFF_FFFF, 32'd1, 1'b0);
    step("sltu_m1_1",   4'b0011, 32'hFFFF_FFFF, 32'd1, 1'b0);
    step("xor_10_5",    4'b0100, 32'd10, 32'd5, 1'b0);
    step("or_20_30",    4'b0110, 32'd20, 32'd30, 1'b0);
    step("and_20_30",   4'b0111, 32'd20, 32'd30, 1'b0);
    step("sub_1_m1",    4'b1000, 32'd1, 32'hFFFF_FFFF, 1'b0);
    step("sub_20_20",   4'b1000, 32'd20, 32'd20, 1'b0);
    step("sub_20_30",   4'b1000, 32'd20, 32'd30, 1'b0);
    step("sub_m2_30",   4'b1000, 32'hFFFF_FFFE, 32'd30, 1'b0);
    step("add_m20_30",  4'b0000, 32'hFFFF_FFEC, 32'd30, 1'b0);
    step("undef_1111",  4'b1111, 32'hDEAD_BEEF, 32'h1, 1'b0);
    step("add_wrap_we", 4'b0000, 32'hFFFF_FFFF, 32'd1, 1'b1);
    step("hold_we0",    4'b0000, 32'd1, 32'd1, 1'b0);
    step("hold_again",  4'b0111, 32'h0, 32'h0, 1'b0);

    // rst mid-cycle must clear the register at once and leave the live result alone.
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midcycle_rst_flags_q", {28'h0, flags_q}, 32'h0);
    chk("midcycle_rst_rd", rd, 32'h0);
    chk("midcycle_rst_flags", {28'h0, flags}, 32'h4);
    #1;
    rst        = 1'b0;
    fq_model   = 4'b0000;
    last_we    = 1'b0;

    for (int i = 0; i < 400; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      step("rand", op, rand_operand(), rand_operand(), 1'($urandom_range(0, 1)));
    end

`ifdef ALU_STICKY_OVF_EN
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("sticky_reset", {31'h0, sticky_ovf}, 32'h0);
    rst        = 1'b0;
    ALUControl = 4'b0000;
    rs1        = 32'hFFFF_FFFF;
    rs2        = 32'd1;
    flags_we   = 1'b1;
    sticky_clr = 1'b0;
    @(posedge clk);
    #1;
    chk("sticky_set", {31'h0, sticky_ovf}, 32'h1);
    sticky_clr = 1'b1;
    @(posedge clk);
    #1;
    chk("sticky_clr_wins", {31'h0, sticky_ovf}, 32'h0);
    sticky_clr = 1'b0;
    flags_we   = 1'b0;
    @(posedge clk);
    #1;
    chk("sticky_hold", {31'h0, sticky_ovf}, 32'h0);
`endif

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
